// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types and constants for the rtc_alarm_clock block.
//   - rtc_state_e : RUN / SET_H / SET_M / SET_S (encoding matches the mode output)
//   - H_W/M_W/S_W : field widths of hours, minutes and seconds
//   - HOUR_MAX/MIN_MAX/SEC_MAX : last legal value of each field
//   - hour_inc / sixty_inc : wrap-around increments used by counting and setting
package rtc_pkg;

  localparam int H_W = 5;
  localparam int M_W = 6;
  localparam int S_W = 6;

  localparam logic [H_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [M_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [S_W-1:0] SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } rtc_state_e;

  // Hour + 1 with 23 -> 0 wrap (no day carry exists).
  function automatic logic [H_W-1:0] hour_inc(input logic [H_W-1:0] h);
    logic [H_W-1:0] r;
    if (h >= HOUR_MAX) begin
      r = 5'd0;
    end else begin
      r = h + 5'd1;
    end
    return r;
  endfunction

  // Minute/second + 1 with 59 -> 0 wrap; caller decides about any carry.
  function automatic logic [5:0] sixty_inc(input logic [5:0] v);
    logic [5:0] r;
    if (v >= 6'd59) begin
      r = 6'd0;
    end else begin
      r = v + 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_alarm_clock_tick_gen.sv
// tick_gen: seconds prescaler.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   run  : count enable; when low the prescaler is forced to 0
//   tick : registered one-cycle pulse on the cycle the prescaler holds TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next prescaler value; the tick flop mirrors "next count is the last one"
  // so the pulse lines up with the cycle the counter holds TICK_DIV-1.
  always_comb begin
    cnt_d  = {CW{1'b0}};
    tick_d = 1'b0;
    if (run) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
    tick_d = (cnt_d == CNT_MAX);
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/rtc_alarm_clock.sv
// rtc_alarm_clock: 24-hour hh:mm:ss clock with key-driven set mode and alarm.
//   clk, rst           : clock, synchronous active-high reset
//   key_mode           : pulse, steps RUN -> SET_H -> SET_M -> SET_S -> RUN
//   key_inc            : pulse, increments (SET_H/SET_M) or clears (SET_S) a field
//   alarm_en           : level, arms the alarm; low also clears an active alarm
//   alarm_h, alarm_m   : alarm time (seconds are always 0)
//   alarm_ack          : pulse, clears an active alarm
//   dout               : {hh[16:12], mm[11:6], ss[5:0]} binary
//   tick_1s            : one-cycle pulse per second while in RUN
//   mode               : current state (0 RUN, 1 SET_H, 2 SET_M, 3 SET_S)
//   alarm              : alarm active, high for ALARM_LEN ticks unless cleared
module rtc_alarm_clock
  import rtc_pkg::*;
#(
  parameter int TICK_DIV  = 20_000_000,
  parameter int ALARM_LEN = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        alarm_en,
  input  logic [4:0]  alarm_h,
  input  logic [5:0]  alarm_m,
  input  logic        alarm_ack,
  output logic [16:0] dout,
  output logic        tick_1s,
  output logic [1:0]  mode,
  output logic        alarm
);

  localparam logic [5:0] DUR_INIT = 6'(ALARM_LEN);

  rtc_state_e     state_q, state_d;
  logic [H_W-1:0] hh_q, hh_d;
  logic [M_W-1:0] mm_q, mm_d;
  logic [S_W-1:0] ss_q, ss_d;
  logic           alarm_q, alarm_d;
  logic [5:0]     dur_q, dur_d;

  logic           tick;
  logic           run_en;
  logic           alarm_match;

  // Prescaler runs only while we stay in RUN across this edge, so it is already
  // 0 on the first SET cycle and restarts from 0 on the first RUN cycle.
  assign run_en = (state_q == RUN) && (state_d == RUN);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (run_en),
    .tick (tick)
  );

  // Mode state machine: each key_mode pulse advances one step.
  always_comb begin
    state_d = state_q;
    if (key_mode) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        SET_S:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Time fields: ripple carry on ticks in RUN; isolated edits in SET states.
  // key_inc acts on the field of the current state even if key_mode leaves it.
  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    case (state_q)
      RUN: begin
        if (tick) begin
          ss_d = sixty_inc(ss_q);
          if (ss_q == SEC_MAX) begin
            mm_d = sixty_inc(mm_q);
            if (mm_q == MIN_MAX) begin
              hh_d = hour_inc(hh_q);
            end else begin
              hh_d = hh_q;
            end
          end else begin
            mm_d = mm_q;
          end
        end else begin
          ss_d = ss_q;
        end
      end
      SET_H: begin
        if (key_inc) begin
          hh_d = hour_inc(hh_q);
        end else begin
          hh_d = hh_q;
        end
      end
      SET_M: begin
        if (key_inc) begin
          mm_d = sixty_inc(mm_q);
        end else begin
          mm_d = mm_q;
        end
      end
      SET_S: begin
        if (key_inc) begin
          ss_d = 6'd0;
        end else begin
          ss_d = ss_q;
        end
      end
      default: begin
        hh_d = hh_q;
      end
    endcase
  end

  // Alarm match looks at the time this tick is about to load, so alarm rises
  // together with dout showing hh:mm:00. Out-of-range settings never match.
  always_comb begin
    alarm_match = 1'b0;
    if (alarm_en && tick && (state_q == RUN) &&
        (alarm_h <= HOUR_MAX) && (alarm_m <= MIN_MAX)) begin
      alarm_match = (hh_d == alarm_h) && (mm_d == alarm_m) && (ss_d == 6'd0);
    end else begin
      alarm_match = 1'b0;
    end
  end

  // Alarm flag and duration counter: clear beats trigger beats countdown.
  always_comb begin
    alarm_d = alarm_q;
    dur_d   = dur_q;
    if (alarm_ack || !alarm_en) begin
      alarm_d = 1'b0;
      dur_d   = 6'd0;
    end else if (alarm_match) begin
      alarm_d = 1'b1;
      dur_d   = DUR_INIT;
    end else if (alarm_q && tick) begin
      if (dur_q <= 6'd1) begin
        alarm_d = 1'b0;
        dur_d   = 6'd0;
      end else begin
        dur_d   = dur_q - 6'd1;
      end
    end else begin
      alarm_d = alarm_q;
    end
  end

  // State, time and alarm registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      hh_q    <= 5'd0;
      mm_q    <= 6'd0;
      ss_q    <= 6'd0;
      alarm_q <= 1'b0;
      dur_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      alarm_q <= alarm_d;
      dur_q   <= dur_d;
    end
  end

  assign dout    = {hh_q, mm_q, ss_q};
  assign mode    = state_q;
  assign tick_1s = tick;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Directed self-checking bench for rtc_alarm_clock with TICK_DIV=4, ALARM_LEN=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rtc_alarm_clock;

  localparam int TD = 4;
  localparam int AL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_mode = 1'b0;
  logic        key_inc = 1'b0;
  logic        alarm_en = 1'b0;
  logic [4:0]  alarm_h = 5'd0;
  logic [5:0]  alarm_m = 6'd0;
  logic        alarm_ack = 1'b0;
  logic [16:0] dout;
  logic        tick_1s;
  logic [1:0]  mode;
  logic        alarm;

  int total = 0;
  int bad = 0;
  int tick_seen = 0;
  int alarm_seen = 0;

  always #5 clk = ~clk;

  rtc_alarm_clock #(
    .TICK_DIV  (TD),
    .ALARM_LEN (AL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .alarm_en  (alarm_en),
    .alarm_h   (alarm_h),
    .alarm_m   (alarm_m),
    .alarm_ack (alarm_ack),
    .dout      (dout),
    .tick_1s   (tick_1s),
    .mode      (mode),
    .alarm     (alarm)
  );

  function automatic logic [16:0] t(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic chk_dout(input string tag, input logic [16:0] exp);
    total++;
    assert (dout === exp) else begin
      bad++;
      $error("FAIL %s: dout=%0d:%0d:%0d expected %0d:%0d:%0d", tag,
             dout[16:12], dout[11:6], dout[5:0], exp[16:12], exp[11:6], exp[5:0]);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, tallying tick and alarm samples.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      tick_seen  += int'(tick_1s);
      alarm_seen += int'(alarm);
    end
  endtask

  task automatic press(input logic m, input logic i);
    key_mode = m;
    key_inc  = i;
    cyc(1);
    key_mode = 1'b0;
    key_inc  = 1'b0;
  endtask

  // From RUN: +dh hours, +dm minutes, clear seconds, back to RUN.
  task automatic set_hm(input int dh, input int dm);
    press(1'b1, 1'b0);
    repeat (dh) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (dm) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk_dout("rst_dout", t(0, 0, 0));
    chk_int("rst_mode", int'(mode), 0);
    chk_bit("rst_tick", tick_1s, 1'b0);
    chk_bit("rst_alarm", alarm, 1'b0);
    rst = 1'b0;

    // Tick cadence: first at cycle 3, then every 4
    for (int c = 0; c < 8; c++) begin
      chk_bit($sformatf("tick_c%0d", c), tick_1s, (c % TD) == (TD - 1));
      cyc(1);
    end
    chk_dout("run_2s", t(0, 0, 2));

    // Set mode
    tick_seen = 0;
    press(1'b1, 1'b0);
    chk_int("mode_seth", int'(mode), 1);
    repeat (25) press(1'b0, 1'b1);
    chk_dout("seth_25", t(1, 0, 2));
    press(1'b1, 1'b1);
    chk_int("simul_mode", int'(mode), 2);
    chk_dout("simul_inc", t(2, 0, 2));
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    chk_int("mode_sets", int'(mode), 3);
    press(1'b0, 1'b1);
    chk_dout("sets_clr", t(2, 3, 0));
    chk_int("set_frozen", tick_seen, 0);
    press(1'b1, 1'b0);
    chk_int("mode_run", int'(mode), 0);
    for (int c = 0; c < 4; c++) begin
      chk_bit($sformatf("reentry_c%0d", c), tick_1s, c == 3);
      cyc(1);
    end
    chk_dout("reentry_dout", t(2, 3, 1));
    press(1'b0, 1'b1);
    chk_dout("inc_in_run", t(2, 3, 1));

    // Count and carry through midnight
    set_hm(21, 56);
    chk_dout("set_235900", t(23, 59, 0));
    cyc(236);
    chk_dout("at_235959", t(23, 59, 59));
    cyc(3);
    chk_bit("midnight_tick", tick_1s, 1'b1);
    cyc(1);
    chk_dout("midnight_wrap", t(0, 0, 0));

    // Alarm duration
    alarm_h = 5'd0;
    alarm_m = 6'd1;
    alarm_en = 1'b1;
    alarm_seen = 0;
    cyc(232);
    chk_dout("at_000058", t(0, 0, 58));
    cyc(7);
    chk_bit("alarm_pre", alarm, 1'b0);
    alarm_seen = 0;
    cyc(1);
    chk_bit("alarm_rise", alarm, 1'b1);
    chk_dout("alarm_rise_dout", t(0, 1, 0));
    cyc(11);
    chk_bit("alarm_hold", alarm, 1'b1);
    cyc(1);
    chk_bit("alarm_fall", alarm, 1'b0);
    chk_dout("alarm_fall_dout", t(0, 1, 3));
    chk_int("alarm_cycles", alarm_seen, AL * TD);

    // Ack on second active cycle
    set_hm(0, 59);
    cyc(240);
    chk_bit("ack_rise", alarm, 1'b1);
    cyc(1);
    alarm_ack = 1'b1;
    cyc(1);
    alarm_ack = 1'b0;
    chk_bit("ack_clear", alarm, 1'b0);
    alarm_seen = 0;
    cyc(2);
    chk_dout("ack_000101", t(0, 1, 1));
    cyc(4);
    chk_int("ack_no_retrig", alarm_seen, 0);

    // Ack in the same cycle as the trigger
    set_hm(0, 59);
    cyc(239);
    chk_bit("same_tick", tick_1s, 1'b1);
    alarm_ack = 1'b1;
    cyc(1);
    alarm_ack = 1'b0;
    chk_dout("same_dout", t(0, 1, 0));
    chk_bit("same_alarm", alarm, 1'b0);
    alarm_seen = 0;
    cyc(8);
    chk_int("same_quiet", alarm_seen, 0);

    // Out-of-range hour across midnight
    set_hm(23, 58);
    alarm_h = 5'd24;
    alarm_m = 6'd0;
    alarm_seen = 0;
    cyc(244);
    chk_dout("oor_dout", t(0, 0, 1));
    chk_int("oor_quiet", alarm_seen, 0);

    // Disarmed across midnight
    alarm_h = 5'd0;
    alarm_en = 1'b0;
    set_hm(23, 59);
    alarm_seen = 0;
    cyc(244);
    chk_dout("dis_dout", t(0, 0, 1));
    chk_int("dis_quiet", alarm_seen, 0);

    // Reset during SET_M with alarm active
    alarm_en = 1'b1;
    set_hm(23, 59);
    cyc(240);
    chk_bit("pre_rst_alarm", alarm, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    cyc(20);
    chk_int("pre_rst_mode", int'(mode), 2);
    chk_bit("alarm_frozen", alarm, 1'b1);
    rst = 1'b1;
    key_inc = 1'b1;
    cyc(1);
    rst = 1'b0;
    key_inc = 1'b0;
    chk_int("mid_rst_mode", int'(mode), 0);
    chk_dout("mid_rst_dout", t(0, 0, 0));
    chk_bit("mid_rst_alarm", alarm, 1'b0);
    chk_bit("mid_rst_tick", tick_1s, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_alarm_clock.md
# rtc_alarm_clock

Parametrised 24-hour time-of-day clock with a key-driven set mode and a programmable alarm. It is the next generation of the free-running hh:mm:ss counter. It adds per-field time setting, a 1 Hz tick output and an alarm at any hh:mm with configurable duration and acknowledge. It sits between the debounced key front-end and the display/beeper logic.

## Interface
- `TICK_DIV`, default 20_000_000: `clk` cycles per second; must be ≥ 2.
- `ALARM_LEN`, default 10: alarm duration in seconds; must be 1..63.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: reset; one clock, reset synchronous and active-high.
- `key_mode` input, 1 bit: single-cycle pulse, debounced upstream; advances the set-mode state.
- `key_inc` input, 1 bit: single-cycle pulse; increments the field selected by the current state.
- `alarm_en` input, 1 bit: alarm arm; level.
- `alarm_h` input, 5 bits: alarm hour, 0..23.
- `alarm_m` input, 6 bits: alarm minute, 0..59.
- `alarm_ack` input, 1 bit: pulse; clears an active alarm.
- `dout` output, 17 bits: {hh[16:12], mm[11:6], ss[5:0]}, binary.
- `tick_1s` output, 1 bit: one-cycle pulse at every second boundary while in RUN.
- `mode` output, 2 bits: current state, 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S.
- `alarm` output, 1 bit: alarm active.

## Operation
- **State machine**
  - On `key_mode` the state steps RUN→SET_H→SET_M→SET_S→RUN.
  - `key_inc` is ignored in RUN.
- **Prescaler**
  - Counts 0..TICK_DIV-1 in RUN only.
  - `tick_1s` is high on the cycle the prescaler holds TICK_DIV-1.
  - In any SET state the prescaler is held at 0 and time is frozen.
  - On re-entry to RUN the first tick comes exactly TICK_DIV cycles later.
- **Time counting in RUN:** on each tick, ss increments.
  - ss 59→0 carries into mm.
  - mm 59→0 carries into hh.
  - hh 23→0; there is no day carry.
- **Setting time**
  - SET_H: `key_inc` does hh+1, wrapping 23→0.
  - SET_M: `key_inc` does mm+1, wrapping 59→0.
  - SET_S: `key_inc` clears ss to 0; no increment.
  - A wrap in any SET state never carries into another field.
- **Simultaneous keys:** if `key_mode` and `key_inc` arrive in the same cycle, `key_inc` applies to the current (pre-transition) field, then the state advances.
- **Alarm trigger**
  - Fires on a RUN tick whose next time value equals {alarm_h, alarm_m, 0} while `alarm_en`=1.
  - On that edge `alarm` is set and the duration counter is loaded with ALARM_LEN.
  - Each later tick decrements the counter.
  - The tick that takes it to 0 clears `alarm`. `alarm` is therefore high for exactly ALARM_LEN ticks.
- **Alarm clear**
  - `alarm_ack`=1 or `alarm_en`=0 clears `alarm` and the counter on the next edge.
  - If a clear and a trigger occur in the same cycle, the clear wins.
- **Alarm and set modes**
  - Setting time never triggers the alarm.
  - An active alarm keeps its counter frozen during SET states, because there are no ticks.
- **Out-of-range alarm values:** alarm_h > 23 or alarm_m > 59 never match.

## Timing
- **Reset values:** `dout`=0, `mode`=0 (RUN), `tick_1s`=0, `alarm`=0, prescaler=0, duration counter=0.
- **Mid-operation reset:** `rst` takes priority over every input in the same cycle; reset mid-alarm or mid-set returns to the reset state.
- **Registered outputs:** all outputs are registered.
- **`dout` latency:** `dout` updates on the clock edge that ends the `tick_1s` cycle, one cycle after `tick_1s` is seen.
- **Key latency:** a key pulse at cycle N is visible on `dout` or `mode` at N+1.
- **`alarm` latency:** `alarm` rises on the same edge as `dout` takes the matching value.
- **First tick after reset:** at cycle TICK_DIV-1.

## Structure
- **Package `rtc_pkg`:**
  - state enum (RUN/SET_H/SET_M/SET_S);
  - field widths (H_W=5, M_W=6, S_W=6);
  - limits (HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59).
- **Sub-module `tick_gen`:**
  - parameter TICK_DIV, with counter width $clog2(TICK_DIV);
  - inputs `clk`, `rst`, `run`;
  - output `tick`.
- **Top level:** FSM, the three field counters and the alarm logic.

## Test plan
- **Count and carry:** TICK_DIV=4, reset, run to 23:59:59 → next tick gives `dout`=0, with ticks every 4 cycles and the first tick at cycle 3.
- **Set mode:** in SET_H press `key_inc` 25× → hh=1 with mm and ss unchanged. Then step to SET_S and press `key_inc` → ss=0. Check the prescaler is frozen throughout.
- **Alarm duration:** alarm 00:01, ALARM_LEN=3, en=1, start at 00:00:58 → `alarm` rises with `dout`=00:01:00 and falls with `dout`=00:01:03.
- **Alarm ack:** `alarm_ack` on the second active cycle → `alarm`=0 next cycle, with no re-trigger at 00:01:01. Also check that ack in the same cycle as the trigger leaves `alarm`=0.
- **Disarmed and out of range:** alarm_h=24, or `alarm_en`=0 → no alarm over a full day wrap.
- **Reset mid-operation:** `rst` during SET_M with `alarm` high → next cycle `mode`=0, `dout`=0, `alarm`=0.
